// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register ids, exception codes, vector constants
// and the packed Status/Cause layouts used by the CP0 register block.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_EBASE    = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  localparam logic [31:0] VEC_BEV1      = 32'hBFC0_0380;
  localparam logic [19:0] VEC_BEV0_BASE = 20'h8_0000;
  localparam logic [11:0] VEC_OFFSET    = 12'h180;

  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [4:0] rsvd_lo;
    logic       erl;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cp0_cause_t;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == CODE_ADEL) || (code == CODE_ADES);
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
  parameter int NUM_HW_INT  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [NUM_HW_INT-1:0] hw_sync
);

  logic [NUM_HW_INT-1:0] stage_q [SYNC_STAGES];

  // Shift each line through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign hw_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 register block: Count/Compare timer with divider, synchronised
// hardware interrupts, registered interrupt request, exception/ERET commit
// and exception-vector generation. Optional EBase register: CP0_EBASE_EN.
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CONFIG_VAL  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            ra,
  output logic [31:0]           rd,
  input  logic                  wvalid,
  input  logic [4:0]            wid,
  input  logic [31:0]           wdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_in_ds,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic [31:0]           exc_vector,
  output logic [31:0]           epc_out,
  output logic [31:0]           status_out,
  output logic [31:0]           cause_out
);

  logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
  cp0_status_t status_q;
  cp0_cause_t  cause;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic        timer_pend_q;
  logic [3:0]  div_q;
  logic        int_req_q;
  logic [7:0]  ip;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic        div_wrap, wr_count, wr_compare, count_inc, timer_hit;
`ifdef CP0_EBASE_EN
  logic [17:0] ebase_q;
`endif

  cp0_int_sync #(
    .NUM_HW_INT (NUM_HW_INT),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_int_sync (
    .clk    (clk),
    .reset  (reset),
    .hw_int (hw_int),
    .hw_sync(hw_sync)
  );

  assign div_wrap   = (div_q == 4'(COUNT_DIV - 1));
  assign wr_count   = wvalid && (wid == REG_COUNT);
  assign wr_compare = wvalid && (wid == REG_COMPARE);
  assign count_inc  = !wr_count && div_wrap;
  assign timer_hit  = count_inc && ((count_q + 32'd1) == compare_q);

  // Pending bits: timer on IP7, synchronised hw lines as levels, sw bits stored.
  always_comb begin
    ip = {timer_pend_q, 5'b0, ip_sw_q};
    for (int i = 0; i < NUM_HW_INT; i++) ip[2+i] = ip[2+i] | hw_sync[i];
    cause          = '0;
    cause.bd       = bd_q;
    cause.ti       = timer_pend_q;
    cause.ip       = ip;
    cause.exc_code = exc_code_q;
  end

  // Count divider, Count, Compare and the sticky timer flag (clear beats set).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
        div_q   <= '0;
      end else begin
        div_q <= div_wrap ? 4'd0 : div_q + 4'd1;
        if (count_inc) count_q <= count_q + 32'd1;
      end
      if (wr_compare) compare_q <= wdata;
      if (wr_compare)     timer_pend_q <= 1'b0;
      else if (timer_hit) timer_pend_q <= 1'b1;
    end
  end

  // MTC0 writes first; exception then ERET assignments follow so commit wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q     <= '0;
      status_q.bev <= 1'b1;
      bd_q         <= 1'b0;
      exc_code_q   <= '0;
      ip_sw_q      <= '0;
      epc_q        <= '0;
      badvaddr_q   <= '0;
`ifdef CP0_EBASE_EN
      ebase_q      <= '0;
`endif
    end else begin
      if (wvalid) begin
        case (wid)
          REG_STATUS: begin
            status_q.ie  <= wdata[0];
            status_q.exl <= wdata[1];
            status_q.im  <= wdata[15:8];
`ifdef CP0_EBASE_EN
            // BEV must be clearable for the EBase-relative vector to be reachable.
            status_q.bev <= wdata[22];
`endif
          end
          REG_CAUSE: ip_sw_q <= wdata[9:8];
          REG_EPC:   epc_q   <= wdata;
`ifdef CP0_EBASE_EN
          REG_EBASE: ebase_q <= wdata[29:12];
`endif
          default: ;
        endcase
      end
      if (exc_valid) begin
        if (!status_q.exl) begin
          epc_q <= exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
          bd_q  <= exc_in_ds;
        end
        exc_code_q   <= exc_code;
        status_q.exl <= 1'b1;
        if (is_addr_err(exc_code)) badvaddr_q <= exc_badvaddr;
      end else if (eret) begin
        if (status_q.erl) status_q.erl <= 1'b0;
        else              status_q.exl <= 1'b0;
      end
    end
  end

  // Interrupt request registered one cycle behind the pending/mask state.
  always_ff @(posedge clk) begin
    if (reset) int_req_q <= 1'b0;
    else int_req_q <= status_q.ie & ~status_q.exl & ~status_q.erl & |(ip & status_q.im);
  end

  // MFC0 read mux.
  always_comb begin
    rd = '0;
    case (ra)
      REG_BADVADDR: rd = badvaddr_q;
      REG_COUNT:    rd = count_q;
      REG_COMPARE:  rd = compare_q;
      REG_STATUS:   rd = status_q;
      REG_CAUSE:    rd = cause;
      REG_EPC:      rd = epc_q;
`ifdef CP0_EBASE_EN
      REG_EBASE:    rd = {2'b10, ebase_q, 12'h000};
`endif
      REG_CONFIG:   rd = CONFIG_VAL;
      default:      rd = '0;
    endcase
  end

  // Exception entry vector from the current BEV.
  always_comb begin
    if (status_q.bev) exc_vector = VEC_BEV1;
`ifdef CP0_EBASE_EN
    else              exc_vector = {2'b10, ebase_q, VEC_OFFSET};
`else
    else              exc_vector = {VEC_BEV0_BASE, VEC_OFFSET};
`endif
  end

  assign int_req    = int_req_q;
  assign epc_out    = epc_q;
  assign status_out = status_q;
  assign cause_out  = cause;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Scoreboard bench for cp0_irq_ctrl (default parameters).
module tb_cp0_irq_ctrl;
  import cp0_pkg::*;

  localparam int NUM_HW_INT  = 6;
  localparam int COUNT_DIV   = 2;
  localparam int SYNC_STAGES = 2;

  localparam int K_RD = 0, K_INT = 1, K_VEC = 2, K_EPC = 3, K_STATUS = 4, K_CAUSE = 5;
  localparam logic [31:0] M_ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] M_TI  = 32'h4000_8000;
  localparam logic [31:0] M_EXC = 32'h8000_007C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] ra = '0;
  logic [31:0] rd;
  logic wvalid = 1'b0;
  logic [4:0] wid = '0;
  logic [31:0] wdata = '0;
  logic [NUM_HW_INT-1:0] hw_int = '0;
  logic exc_valid = 1'b0;
  logic [4:0] exc_code = '0;
  logic [31:0] exc_pc = '0;
  logic exc_in_ds = 1'b0;
  logic [31:0] exc_badvaddr = '0;
  logic eret = 1'b0;
  logic int_req;
  logic [31:0] exc_vector, epc_out, status_out, cause_out;

  cp0_irq_ctrl #(
    .NUM_HW_INT (NUM_HW_INT),
    .COUNT_DIV  (COUNT_DIV),
    .SYNC_STAGES(SYNC_STAGES),
    .CONFIG_VAL (32'h8000_0000)
  ) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd),
    .wvalid(wvalid), .wid(wid), .wdata(wdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_in_ds(exc_in_ds), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .int_req(int_req), .exc_vector(exc_vector), .epc_out(epc_out),
    .status_out(status_out), .cause_out(cause_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  id;
    logic [31:0] mask;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_status = 32'h0040_0000;
  logic [31:0] m_ebase  = 32'h8000_0000;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] status_wr(input logic [31:0] old, input logic [31:0] d);
    logic [31:0] wm;
    wm = 32'h0000_FF03;
`ifdef CP0_EBASE_EN
    wm = wm | 32'h0040_0000;
`endif
    return (old & ~wm) | (d & wm);
  endfunction

  function automatic logic [31:0] exp_vec();
    if (m_status[22]) return 32'hBFC0_0380;
`ifdef CP0_EBASE_EN
    return {m_ebase[31:12], 12'h180};
`else
    return 32'h8000_0180;
`endif
  endfunction

  task automatic push(input string tag, input int kind, input logic [4:0] id,
                      input logic [31:0] mask, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.id = id; e.mask = mask; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      ra = e.id;
      #1;
      case (e.kind)
        K_RD:     act = rd;
        K_INT:    act = {31'b0, int_req};
        K_VEC:    act = exc_vector;
        K_EPC:    act = epc_out;
        K_STATUS: act = status_out;
        default:  act = cause_out;
      endcase
      check_val(e.tag, act & e.mask, e.exp & e.mask);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic mtc0(input logic [4:0] id, input logic [31:0] d);
    wvalid = 1'b1; wid = id; wdata = d;
    if (id == REG_STATUS) m_status = status_wr(m_status, d);
`ifdef CP0_EBASE_EN
    if (id == REG_EBASE) m_ebase = {2'b10, d[29:12], 12'h000};
`endif
    step();
    wvalid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    push("reset_status", K_RD, REG_STATUS, M_ALL, 32'h0040_0000);
    push("reset_int_req", K_INT, 5'd0, M_ALL, 32'h0);
    push("reset_vector", K_VEC, 5'd0, M_ALL, 32'hBFC0_0380);
    push("reset_cause", K_CAUSE, 5'd0, M_ALL, 32'h0);
    push("reset_count", K_RD, REG_COUNT, M_ALL, 32'h0);
    drain();
    reset = 1'b0;

    // Plain register writes and read-only / undefined ids.
    mtc0(REG_EPC, 32'h1234_5678);
    push("epc_out_wr", K_EPC, 5'd0, M_ALL, 32'h1234_5678);
    push("epc_rd_wr", K_RD, REG_EPC, M_ALL, 32'h1234_5678);
    drain();
    mtc0(REG_BADVADDR, 32'h0000_FFFF);
    push("badvaddr_ro", K_RD, REG_BADVADDR, M_ALL, 32'h0);
    mtc0(REG_CONFIG, 32'h0);
    push("config_ro", K_RD, REG_CONFIG, M_ALL, 32'h8000_0000);
    mtc0(5'd3, 32'hFFFF_FFFF);
    push("undef_rd", K_RD, 5'd3, M_ALL, 32'h0);
    drain();
`ifndef CP0_EBASE_EN
    mtc0(REG_EBASE, 32'hFFFF_FFFF);
    push("ebase_absent", K_RD, REG_EBASE, M_ALL, 32'h0);
    drain();
`endif
    mtc0(REG_STATUS, 32'hFFFF_FFFF);
    push("status_wmask", K_STATUS, 5'd0, M_ALL, m_status);
    drain();
    mtc0(REG_STATUS, 32'h0);
    push("vector_after_status", K_VEC, 5'd0, M_ALL, exp_vec());
    drain();

    // Software interrupts.
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    push("cause_sw_only", K_CAUSE, 5'd0, M_ALL, 32'h0000_0300);
    drain();
    mtc0(REG_STATUS, 32'h0000_0101);
    push("sw_int_lat0", K_INT, 5'd0, M_ALL, 32'h0);
    drain();
    step();
    push("sw_int_req", K_INT, 5'd0, M_ALL, 32'h1);
    drain();
    mtc0(REG_STATUS, 32'h0000_0103);
    step();
    push("exl_masks_int", K_INT, 5'd0, M_ALL, 32'h0);
    drain();
    mtc0(REG_CAUSE, 32'h0);
    mtc0(REG_STATUS, 32'h0);

    // Count divider and timer.
    mtc0(REG_COMPARE, 32'd8);
    mtc0(REG_COUNT, 32'd5);
    push("count_load", K_RD, REG_COUNT, M_ALL, 32'd5);
    push("ti_before", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();
    step(5);
    push("count_minus1", K_RD, REG_COUNT, M_ALL, 32'd7);
    push("ti_still_low", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();
    step();
    push("count_eq_compare", K_RD, REG_COUNT, M_ALL, 32'd8);
    drain();
    step();
    push("timer_ti_ip7", K_CAUSE, 5'd0, M_TI, M_TI);
    drain();
    mtc0(REG_COMPARE, 32'd20);
    push("timer_clear", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();

    // Compare write on the very edge the timer would fire: clear wins.
    mtc0(REG_COMPARE, 32'd8);
    mtc0(REG_COUNT, 32'd5);
    step(5);
    mtc0(REG_COMPARE, 32'd8);
    push("count_at_clear", K_RD, REG_COUNT, M_ALL, 32'd8);
    push("clear_wins", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();
    step();
    push("clear_wins_after", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();

    // Count wrap with Compare = 0.
    mtc0(REG_COMPARE, 32'd0);
    mtc0(REG_COUNT, 32'hFFFF_FFFE);
    step(3);
    push("count_max", K_RD, REG_COUNT, M_ALL, 32'hFFFF_FFFF);
    push("ti_pre_wrap", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();
    step();
    push("count_wrap", K_RD, REG_COUNT, M_ALL, 32'h0);
    drain();
    step();
    push("timer_cmp0", K_CAUSE, 5'd0, M_TI, M_TI);
    drain();
    mtc0(REG_COMPARE, 32'h7000_0000);
    push("timer_clear2", K_CAUSE, 5'd0, M_TI, 32'h0);
    drain();

    // Hardware interrupt latency through the synchroniser.
    mtc0(REG_STATUS, 32'h0000_0401);
    hw_int = 6'b000001;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      step();
      push($sformatf("hw_rise_int_c%0d", k), K_INT, 5'd0, M_ALL, {31'b0, k == SYNC_STAGES + 1});
      push($sformatf("hw_rise_ip2_c%0d", k), K_CAUSE, 5'd0, 32'h400, (k >= SYNC_STAGES) ? 32'h400 : 32'h0);
      drain();
    end
    hw_int = 6'b000000;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      step();
      push($sformatf("hw_fall_int_c%0d", k), K_INT, 5'd0, M_ALL, {31'b0, k < SYNC_STAGES + 1});
      push($sformatf("hw_fall_ip2_c%0d", k), K_CAUSE, 5'd0, 32'h400, (k < SYNC_STAGES) ? 32'h400 : 32'h0);
      drain();
    end
    hw_int = 6'b000010;
    step(SYNC_STAGES + 2);
    push("masked_hw_int", K_INT, 5'd0, M_ALL, 32'h0);
    push("masked_hw_ip3", K_CAUSE, 5'd0, 32'h800, 32'h800);
    drain();
    hw_int = '0;
    mtc0(REG_STATUS, 32'h0);
    step(SYNC_STAGES + 1);

    // Exception commit in a delay slot, then a nested exception.
    exc_valid = 1'b1; exc_code = CODE_ADEL; exc_pc = 32'h8000_1004;
    exc_in_ds = 1'b1; exc_badvaddr = 32'h0000_1235;
    step();
    exc_valid = 1'b0;
    m_status[1] = 1'b1;
    push("exc_epc_ds", K_EPC, 5'd0, M_ALL, 32'h8000_1000);
    push("exc_bd_code", K_CAUSE, 5'd0, M_EXC, 32'h8000_0010);
    push("exc_exl", K_STATUS, 5'd0, M_ALL, m_status);
    push("exc_badvaddr", K_RD, REG_BADVADDR, M_ALL, 32'h0000_1235);
    drain();
    exc_valid = 1'b1; exc_code = CODE_INT; exc_pc = 32'h9000_0000;
    exc_in_ds = 1'b0; exc_badvaddr = 32'h0000_DEAD;
    step();
    exc_valid = 1'b0;
    push("nested_epc_hold", K_EPC, 5'd0, M_ALL, 32'h8000_1000);
    push("nested_bd_code", K_CAUSE, 5'd0, M_EXC, 32'h8000_0000);
    push("nested_bva_hold", K_RD, REG_BADVADDR, M_ALL, 32'h0000_1235);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;
    m_status[1] = 1'b0;
    push("eret_clears_exl", K_STATUS, 5'd0, M_ALL, m_status);
    drain();

    // MTC0 Status + exception + ERET in one cycle.
    wvalid = 1'b1; wid = REG_STATUS; wdata = 32'h0000_0001;
    exc_valid = 1'b1; exc_code = CODE_ADES; exc_pc = 32'h8000_2000;
    exc_in_ds = 1'b0; exc_badvaddr = 32'h0000_0044;
    eret = 1'b1;
    m_status = status_wr(m_status, 32'h0000_0001);
    m_status[1] = 1'b1;
    step();
    wvalid = 1'b0; exc_valid = 1'b0; eret = 1'b0;
    push("combo_status", K_STATUS, 5'd0, M_ALL, m_status);
    push("combo_epc", K_EPC, 5'd0, M_ALL, 32'h8000_2000);
    push("combo_cause", K_CAUSE, 5'd0, M_EXC, 32'h0000_0014);
    push("combo_badvaddr", K_RD, REG_BADVADDR, M_ALL, 32'h0000_0044);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;
    m_status[1] = 1'b0;
    push("combo_eret", K_STATUS, 5'd0, M_ALL, m_status);
    push("combo_vector", K_VEC, 5'd0, M_ALL, exp_vec());
    drain();

`ifdef CP0_EBASE_EN
    mtc0(REG_STATUS, 32'h0);
    mtc0(REG_EBASE, 32'h8003_0000);
    push("ebase_rd", K_RD, REG_EBASE, M_ALL, m_ebase);
    push("ebase_vector", K_VEC, 5'd0, M_ALL, 32'h8003_0180);
    drain();
    mtc0(REG_EBASE, 32'hFFFF_FFFF);
    push("ebase_mask", K_RD, REG_EBASE, M_ALL, 32'hBFFF_F000);
    drain();
`endif

    // Reset in the middle of a pending interrupt and timer flag.
    mtc0(REG_COMPARE, 32'd8);
    mtc0(REG_COUNT, 32'd5);
    mtc0(REG_CAUSE, 32'h0000_0100);
    mtc0(REG_STATUS, 32'h0000_0101);
    step(5);
    push("pre_reset_int", K_INT, 5'd0, M_ALL, 32'h1);
    push("pre_reset_ti", K_CAUSE, 5'd0, M_TI, M_TI);
    drain();
    reset = 1'b1;
    step();
    m_status = 32'h0040_0000;
    push("mid_reset_int", K_INT, 5'd0, M_ALL, 32'h0);
    push("mid_reset_cause", K_CAUSE, 5'd0, M_ALL, 32'h0);
    push("mid_reset_status", K_STATUS, 5'd0, M_ALL, m_status);
    push("mid_reset_count", K_RD, REG_COUNT, M_ALL, 32'h0);
    push("mid_reset_epc", K_EPC, 5'd0, M_ALL, 32'h0);
    drain();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
